// File: rtl/led_pkg.sv
// Shared definitions for the LED blink bank: channel mode encodings and
// the width of the channel index on the configuration port.
package led_pkg;
  localparam int CH_IDX_W = 4;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;
endpackage

// File: rtl/blink_channel.sv
// One LED channel: mode, half-period, counter and LED state, with
// write/sync priority resolved in a single next-state block.
module blink_channel
  import led_pkg::*;
#(
  parameter int          CNT_W        = 25,
  parameter int unsigned DEFAULT_HALF = 12500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  mode_e            cfg_mode,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic             sync,
  output logic             led
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             led_q, led_d;
  logic [CNT_W-1:0] last_cnt;
  logic             wrap;

  // H==0 runs as H==1, so the wrap point bottoms out at zero
  assign last_cnt = (half_q == '0) ? '0 : half_q - ONE;
  assign wrap     = (cnt_q == last_cnt);

  always_comb begin
    mode_d = mode_q;
    half_d = half_q;
    cnt_d  = cnt_q;
    led_d  = led_q;
    if (cfg_wr) begin
      mode_d = cfg_mode;
      half_d = cfg_half;
      cnt_d  = '0;
      if (cfg_mode == MODE_BLINK)
        led_d = (mode_q == MODE_BLINK) ? led_q : 1'b0;
      else
        led_d = (cfg_mode == MODE_ON);
    end else if (mode_q == MODE_BLINK) begin
      if (wrap) begin
        cnt_d = '0;
        led_d = ~led_q;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = '0;
      led_d = (mode_q == MODE_ON);
    end
    // sync lands after the write so it wins on counter and LED phase
    if (sync) begin
      cnt_d = '0;
      if (mode_d == MODE_BLINK) led_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_BLINK;
      half_q <= CNT_W'(DEFAULT_HALF);
      cnt_q  <= '0;
      led_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      half_q <= half_d;
      cnt_q  <= cnt_d;
      led_q  <= led_d;
    end
  end

  assign led = led_q;
endmodule

// File: rtl/led_blink_bank.sv
// Bank of independently configurable LED blinkers; decodes the config
// write to one channel and broadcasts the phase sync to all of them.
module led_blink_bank
  import led_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 25,
  parameter int unsigned DEFAULT_HALF = 12500000
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Cfg_Wr,
  input  logic [CH_IDX_W-1:0] i_Cfg_Ch,
  input  logic [1:0]          i_Cfg_Mode,
  input  logic [CNT_W-1:0]    i_Cfg_Half,
  input  logic                i_Sync,
  output logic [NUM_CH-1:0]   o_LED
);
  logic [NUM_CH-1:0] ch_wr;

  // out-of-range channel indices match no instance and are dropped
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_wr[g] = i_Cfg_Wr && (i_Cfg_Ch == CH_IDX_W'(g));

    blink_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk      (i_Clk),
      .rst      (i_Rst),
      .cfg_wr   (ch_wr[g]),
      .cfg_mode (mode_e'(i_Cfg_Mode)),
      .cfg_half (i_Cfg_Half),
      .sync     (i_Sync),
      .led      (o_LED[g])
    );
  end
endmodule

// File: doc/led_blink_bank.md
LED_BLINK_BANK -- requirements
Module: led_blink_bank

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of LED channels, 1..16.
REQ-002 The block SHALL have parameter CNT_W, default 25: half-period counter width in bits.
REQ-003 The block SHALL have parameter DEFAULT_HALF, default 12500000: half-period loaded at reset (1 Hz at 25 MHz).
REQ-004 The block SHALL have port i_Clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port i_Rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port i_Cfg_Wr, input, 1 bit: a one-cycle configuration write strobe.
REQ-007 The block SHALL have port i_Cfg_Ch, input, 4 bits: the target channel index.
REQ-008 The block SHALL have port i_Cfg_Mode, input, 2 bits: the channel mode (00 OFF, 01 ON, 10 BLINK, 11 reserved).
REQ-009 The block SHALL have port i_Cfg_Half, input, CNT_W bits: half-period in clock cycles.
REQ-010 The block SHALL have port i_Sync, input, 1 bit: a one-cycle strobe that realigns all channel phases.
REQ-011 The block SHALL have port o_LED, output, NUM_CH bits: LED drive, registered.

Function
REQ-012 Each channel SHALL hold a mode register, a half-period register H, a counter and an LED state register.
REQ-013 In BLINK mode with H>=1, the counter SHALL count 0..H-1, the LED SHALL toggle on the edge where count==H-1, and the counter SHALL return to 0, giving a full period of 2*H cycles.
REQ-014 In BLINK mode with H==0, the channel SHALL behave as H==1, toggling every cycle.
REQ-015 In OFF mode, the channel SHALL drive its LED 0 and hold its counter at 0.
REQ-016 In ON mode, the channel SHALL drive its LED 1 and hold its counter at 0.
REQ-017 Reserved mode 11 SHALL behave as OFF.
REQ-018 A write (i_Cfg_Wr=1) with i_Cfg_Ch<NUM_CH SHALL update that channel's mode and H on the same edge and clear its counter to 0.
REQ-019 A write that changes the mode from BLINK to BLINK SHALL retain the LED state.
REQ-020 A write that changes the mode into BLINK from OFF or ON SHALL start the LED at 0.
REQ-021 A write with i_Cfg_Ch>=NUM_CH SHALL be ignored with no state change.
REQ-022 A write SHALL affect only its target channel; all other channels SHALL continue uninterrupted.
REQ-023 The first toggle after a write to BLINK SHALL occur H cycles after the write edge.
REQ-024 On i_Sync=1, all channels SHALL clear their counters to 0 and set their BLINK-mode LED state to 0 on that edge.
REQ-025 When i_Sync and i_Cfg_Wr are asserted in the same cycle, the write SHALL be applied and the sync SHALL be applied to all channels, including the written one, with sync winning on counter and LED state.
REQ-026 When a counter wrap and a write to the same channel occur in the same cycle, the write SHALL win: no toggle, and the counter cleared.
REQ-027 A newly written H SHALL be sampled at the write edge; the output SHALL reflect the new mode one cycle after the write edge.
REQ-028 Counter compare SHALL be unsigned CNT_W-bit; the counter SHALL never exceed H-1 and never overflow.

Reset
REQ-029 While i_Rst=1, independent of i_Clk, every channel SHALL set mode to BLINK, H to DEFAULT_HALF, counter to 0 and LED state to 0; o_LED SHALL be all zeros.
REQ-030 Reset asserted mid-period SHALL abort the period; after release, the first toggle SHALL occur DEFAULT_HALF cycles after the first rising edge.
REQ-031 Writes and syncs presented during reset SHALL be ignored.

Structure
REQ-032 The mode encodings (OFF, ON, BLINK) and the channel-index width SHALL live in a shared package/include, led_pkg.
REQ-033 Per-channel logic SHALL be one sub-module, blink_channel (parameter CNT_W), instantiated NUM_CH times via generate; the top level SHALL only decode writes and fan out i_Sync.

Verification
REQ-034 Bench parameters SHALL be NUM_CH=4, CNT_W=8, DEFAULT_HALF=5.
REQ-035 Reset release, no writes -> all o_LED toggle together on cycles 5, 10, 15 after release (period 10).
REQ-036 Write ch2 BLINK H=3 at cycle 7 -> ch2 toggles at cycles 10, 13, 16; channels 0, 1 and 3 unchanged.
REQ-037 Write ch1 ON, then ch1 OFF, then ch1 BLINK H=2 -> o_LED[1] shows 1, then 0, then 0 for 2 cycles, then 1.
REQ-038 Write ch3 BLINK H=0 -> o_LED[3] toggles every cycle.
REQ-039 Write ch9 -> no change on any channel.
REQ-040 i_Sync coincident with a ch0 wrap and with a write to ch0 H=4 -> all LEDs 0 and counters 0, then ch0 toggles 4 cycles later and the others 5 cycles later.
REQ-041 Async i_Rst pulse between clock edges mid-blink -> o_LED=0 immediately; after release, the 5-cycle toggle resumes.
